// File: rtl/odom_scheduler_pkg.sv
// odom_pkg: shared FSM state type and sizing constants for the odometry scheduler.
package odom_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, START, WAIT, CAPTURE} state_t;
    localparam int DEFAULT_DATAWIDTH_N = 32;
    localparam int OVERRUN_W = 16;
endpackage

// File: rtl/odom_scheduler_if.sv
// odom_scheduler_if: operand, calculator-result and pose bus between front end, scheduler and calculator.
interface odom_scheduler_if
    import odom_pkg::*;
#(
    parameter int DATAWIDTH_N = DEFAULT_DATAWIDTH_N
);
    logic                   ODOM_SCHEDULER_Enable_In;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_W1_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_W2_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_W3_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_W4_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_THETA_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CW1_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CW2_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CW3_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CW4_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CTHETA_OutBus;
    logic                   ODOM_SCHEDULER_SETBEGIN_OutLow;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CPOSX_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CPOSY_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_CTHETA_InBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_POSX_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_POSY_OutBus;
    logic [DATAWIDTH_N-1:0] ODOM_SCHEDULER_THETA_OutBus;
    logic                   ODOM_SCHEDULER_Valid_Out;
    logic                   ODOM_SCHEDULER_Busy_Out;
`ifdef ODOM_SCHEDULER_OVERRUN_EN
    logic [OVERRUN_W-1:0]   ODOM_SCHEDULER_Overrun_OutBus;
`endif

    modport master (
        input  ODOM_SCHEDULER_Enable_In,
        input  ODOM_SCHEDULER_W1_InBus, ODOM_SCHEDULER_W2_InBus, ODOM_SCHEDULER_W3_InBus,
        input  ODOM_SCHEDULER_W4_InBus, ODOM_SCHEDULER_THETA_InBus,
        input  ODOM_SCHEDULER_CPOSX_InBus, ODOM_SCHEDULER_CPOSY_InBus, ODOM_SCHEDULER_CTHETA_InBus,
        output ODOM_SCHEDULER_CW1_OutBus, ODOM_SCHEDULER_CW2_OutBus, ODOM_SCHEDULER_CW3_OutBus,
        output ODOM_SCHEDULER_CW4_OutBus, ODOM_SCHEDULER_CTHETA_OutBus, ODOM_SCHEDULER_SETBEGIN_OutLow,
        output ODOM_SCHEDULER_POSX_OutBus, ODOM_SCHEDULER_POSY_OutBus, ODOM_SCHEDULER_THETA_OutBus,
`ifdef ODOM_SCHEDULER_OVERRUN_EN
        output ODOM_SCHEDULER_Overrun_OutBus,
`endif
        output ODOM_SCHEDULER_Valid_Out, ODOM_SCHEDULER_Busy_Out
    );

    modport slave (
        output ODOM_SCHEDULER_Enable_In,
        output ODOM_SCHEDULER_W1_InBus, ODOM_SCHEDULER_W2_InBus, ODOM_SCHEDULER_W3_InBus,
        output ODOM_SCHEDULER_W4_InBus, ODOM_SCHEDULER_THETA_InBus,
        output ODOM_SCHEDULER_CPOSX_InBus, ODOM_SCHEDULER_CPOSY_InBus, ODOM_SCHEDULER_CTHETA_InBus,
        input  ODOM_SCHEDULER_CW1_OutBus, ODOM_SCHEDULER_CW2_OutBus, ODOM_SCHEDULER_CW3_OutBus,
        input  ODOM_SCHEDULER_CW4_OutBus, ODOM_SCHEDULER_CTHETA_OutBus, ODOM_SCHEDULER_SETBEGIN_OutLow,
        input  ODOM_SCHEDULER_POSX_OutBus, ODOM_SCHEDULER_POSY_OutBus, ODOM_SCHEDULER_THETA_OutBus,
`ifdef ODOM_SCHEDULER_OVERRUN_EN
        input  ODOM_SCHEDULER_Overrun_OutBus,
`endif
        input  ODOM_SCHEDULER_Valid_Out, ODOM_SCHEDULER_Busy_Out
    );
endinterface

// File: rtl/odom_scheduler_tick_gen.sv
// odom_tick_gen: enable-gated period counter emitting a registered one-cycle tick every PERIOD_CYCLES clocks.
module odom_tick_gen #(
    parameter int PERIOD_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic          term;
    assign term = cnt == CW'(PERIOD_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (!enable || term) ? '0 : cnt + 1'b1;
            tick <= enable && term;
        end
    end
endmodule

// File: rtl/odom_scheduler.sv
// odom_scheduler: snapshots operands on each tick, pulses the calculator start, captures the pose after CALC_LATENCY.
// Defining ODOM_SCHEDULER_OVERRUN_EN adds a saturating dropped-tick counter.
module odom_scheduler
    import odom_pkg::*;
#(
    parameter int DATAWIDTH_N   = DEFAULT_DATAWIDTH_N,
    parameter int PERIOD_CYCLES = 500000,
    parameter int CALC_LATENCY  = 8
) (
    input  logic ODOM_SCHEDULER_CLOCK_50,
    input  logic ODOM_SCHEDULER_Reset_InLow,
    odom_scheduler_if.master bus
);
    localparam int WW = CALC_LATENCY > 1 ? $clog2(CALC_LATENCY) : 1;
    logic                   clk, rst_n, tick, cap;
    state_t                 state_q, state_d;
    logic [WW-1:0]          wcnt;
    logic [DATAWIDTH_N-1:0] opnd [5];
    logic [DATAWIDTH_N-1:0] pose [3];
    logic                   set_begin_n, valid;
    assign clk   = ODOM_SCHEDULER_CLOCK_50;
    assign rst_n = ODOM_SCHEDULER_Reset_InLow;

    odom_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
        .clk(clk), .rst_n(rst_n), .enable(bus.ODOM_SCHEDULER_Enable_In), .tick(tick)
    );

    assign cap = state_q == WAIT && wcnt == '0;
    always_comb begin
        state_d = state_q == IDLE  ? (tick ? LATCH : IDLE) :
                  state_q == LATCH ? START :
                  state_q == START ? WAIT :
                  state_q == WAIT  ? (cap ? CAPTURE : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // pose is loaded on the edge entering CAPTURE so it appears together with the valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd        <= '{default: '0};
            pose        <= '{default: '0};
            wcnt        <= '0;
            set_begin_n <= 1'b1;
            valid       <= 1'b0;
        end else begin
            if (state_q == LATCH)
                opnd <= '{bus.ODOM_SCHEDULER_W1_InBus, bus.ODOM_SCHEDULER_W2_InBus, bus.ODOM_SCHEDULER_W3_InBus,
                          bus.ODOM_SCHEDULER_W4_InBus, bus.ODOM_SCHEDULER_THETA_InBus};
            if (cap)
                pose <= '{bus.ODOM_SCHEDULER_CPOSX_InBus, bus.ODOM_SCHEDULER_CPOSY_InBus, bus.ODOM_SCHEDULER_CTHETA_InBus};
            wcnt        <= state_q == START ? WW'(CALC_LATENCY - 1) : (state_q == WAIT && !cap) ? wcnt - 1'b1 : wcnt;
            set_begin_n <= state_q != LATCH;
            valid       <= cap;
        end
    end

`ifdef ODOM_SCHEDULER_OVERRUN_EN
    logic [OVERRUN_W-1:0] overrun;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       overrun <= '0;
        else if (tick && state_q != IDLE && overrun != '1) overrun <= overrun + 1'b1;
    end
    assign bus.ODOM_SCHEDULER_Overrun_OutBus = overrun;
`endif

    assign bus.ODOM_SCHEDULER_CW1_OutBus      = opnd[0];
    assign bus.ODOM_SCHEDULER_CW2_OutBus      = opnd[1];
    assign bus.ODOM_SCHEDULER_CW3_OutBus      = opnd[2];
    assign bus.ODOM_SCHEDULER_CW4_OutBus      = opnd[3];
    assign bus.ODOM_SCHEDULER_CTHETA_OutBus   = opnd[4];
    assign bus.ODOM_SCHEDULER_POSX_OutBus     = pose[0];
    assign bus.ODOM_SCHEDULER_POSY_OutBus     = pose[1];
    assign bus.ODOM_SCHEDULER_THETA_OutBus    = pose[2];
    assign bus.ODOM_SCHEDULER_SETBEGIN_OutLow = set_begin_n;
    assign bus.ODOM_SCHEDULER_Valid_Out       = valid;
    assign bus.ODOM_SCHEDULER_Busy_Out        = state_q != IDLE;
endmodule
